lab5_ram_arbiter: RTL

//  Shares one Lab5RAM instance (single port, 8-bit data, 64 words) between two requesters.

---
 rtl/lab5_ram_pkg.sv | 12 +
 rtl/lab5_ram_arbiter_rr_arb2.sv | 19 +
 rtl/lab5_ram_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lab5_ram_pkg.sv
// Shared defaults and FSM state encoding for the Lab5RAM two-requester arbiter.
package lab5_ram_pkg;
  localparam int AW_DEF     = 6;
  localparam int DW_DEF     = 8;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;
endpackage

// File: rtl/lab5_ram_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; ptr names the requester favoured on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // One-hot winner, or zero when nobody asks.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/lab5_ram_arbiter.sv
// Shares one single-port Lab5RAM between two requesters: round-robin grant,
// one registered strobe cycle per access, read data returned with a valid pulse.
module lab5_ram_arbiter
  import lab5_ram_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [DW-1:0] ram_in,
  output logic [AW-1:0] ram_addr,
  output logic          ram_cs,
  output logic          ram_wr,
  input  logic [DW-1:0] ram_out
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t             r_state;
  logic               r_ptr;
  logic               r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ram_cs;
  logic               r_ram_wr;
  logic [AW-1:0]      r_ram_addr;
  logic [DW-1:0]      r_ram_in;
  logic [1:0]         r_rvalid;
  logic [DW-1:0]      r_rdata0;
  logic [DW-1:0]      r_rdata1;
  logic [1:0]         w_req;
  logic [1:0]         w_gnt;

  // Requests are only visible to the picker while idle, so gnt is an IDLE-only Mealy output.
  assign w_req = (r_state == IDLE) ? {req1, req0} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  // FSM, request latch (held in the RAM strobe registers), latency counter and read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_ram_cs   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_in   <= '0;
      r_rvalid   <= 2'b00;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_rvalid <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_gnt != 2'b00) begin
            r_owner    <= w_gnt[1];
            r_ptr      <= ~w_gnt[1];
            r_ram_cs   <= 1'b1;
            r_ram_wr   <= w_gnt[1] ? wr1 : wr0;
            r_ram_addr <= w_gnt[1] ? addr1 : addr0;
            r_ram_in   <= w_gnt[1] ? wdata1 : wdata0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_ram_cs <= 1'b0;
          r_ram_wr <= 1'b0;
          if (r_ram_wr) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= CNT_W'(RD_LAT);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_owner) r_rdata1 <= ram_out;
            else         r_rdata0 <= ram_out;
            r_rvalid[r_owner] <= 1'b1;
            r_state           <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_ram_cs <= 1'b0;
          r_ram_wr <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign gnt0     = w_gnt[0];
  assign gnt1     = w_gnt[1];
  assign busy     = (r_state != IDLE);
  assign ram_cs   = r_ram_cs;
  assign ram_wr   = r_ram_wr;
  assign ram_addr = r_ram_addr;
  assign ram_in   = r_ram_in;
  assign rvalid0  = r_rvalid[0];
  assign rvalid1  = r_rvalid[1];
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;

endmodule
